// File: rtl/mem_rsp_router_pkg.sv
// mem_rsp_router_pkg: shared constants, output indices and entry type for the L2 response router.
// Revision 1.0
`default_nettype none

package mem_rsp_router_pkg;

  function automatic int sel_bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_L1_OUTPUTS  = 5;
  localparam int L1_DATA_WIDTH   = 512;
  localparam int L1_TAG_WIDTH    = 16;
  localparam int L2_RSP_SEL_BITS = sel_bits_for(NUM_L1_OUTPUTS);

  // Output slots in enable order: tex, raster, rop follow the two core caches.
  localparam int ICACHE_RSP_IDX = 0;
  localparam int DCACHE_RSP_IDX = 1;
  localparam int TCACHE_RSP_IDX = 2;
  localparam int RCACHE_RSP_IDX = 3;
  localparam int OCACHE_RSP_IDX = 4;

  typedef struct packed {
    logic [L1_DATA_WIDTH-1:0] data;
    logic [L1_TAG_WIDTH-1:0]  tag;
  } mem_rsp_entry_t;

endpackage

`default_nettype wire

// File: rtl/mem_rsp_router_if.sv
// mem_rsp_router_if: input response stream plus flattened per-output response channels.
// Revision 1.0
`default_nettype none

interface mem_rsp_router_if
  import mem_rsp_router_pkg::*;
#(
  parameter int NUM_OUTPUTS = 5,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 16,
  parameter int SEL_BITS    = sel_bits_for(NUM_OUTPUTS)
);
  logic                              mem_rsp_valid;
  logic [DATA_WIDTH-1:0]             mem_rsp_data;
  logic [TAG_WIDTH+SEL_BITS-1:0]     mem_rsp_tag;
  logic                              mem_rsp_ready;
  logic [NUM_OUTPUTS-1:0]            rsp_valid;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] rsp_data;
  logic [NUM_OUTPUTS*TAG_WIDTH-1:0]  rsp_tag;
  logic [NUM_OUTPUTS-1:0]            rsp_ready;

  modport master (
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag, rsp_ready,
    input  mem_rsp_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag, rsp_ready,
    output mem_rsp_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

`default_nettype wire

// File: rtl/mem_rsp_skid_buf.sv
// mem_rsp_skid_buf: 2-entry registered FIFO; caller never pushes when full nor pops when empty.
// Revision 1.0
`default_nettype none

module mem_rsp_skid_buf #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic      [1:0]       count,
  output logic      [WIDTH-1:0] head
);
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_e0;
  logic [WIDTH-1:0] r_e1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry 0 is always the head; simultaneous push/pop at one entry overwrites it in place.
  always_ff @(posedge clk) begin
    if (pop && r_count == 2'd2) begin
      r_e0 <= r_e1;
    end
    if (push) begin
      if (r_count == 2'd0 || (r_count == 2'd1 && pop)) begin
        r_e0 <= din;
      end else begin
        r_e1 <= din;
      end
    end
  end

  assign count = r_count;
  assign head  = r_e0;
endmodule

`default_nettype wire

// File: rtl/mem_rsp_router.sv
// mem_rsp_router: strips the select field from L2 response tags and routes to per-L1 buffered outputs.
// Revision 1.0 -- optional MEM_RSP_ROUTER_PERF_EN adds perf_rsp_count / perf_stall_cycles.
`default_nettype none

module mem_rsp_router
  import mem_rsp_router_pkg::*;
#(
  parameter int NUM_OUTPUTS = 5,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_rsp_router_if.slave   bus,
`ifdef MEM_RSP_ROUTER_PERF_EN
  output logic [63:0]       perf_rsp_count,
  output logic [63:0]       perf_stall_cycles,
`endif
  output logic              sel_error
);
  localparam int SEL_BITS = sel_bits_for(NUM_OUTPUTS);
  localparam int ENT_W    = DATA_WIDTH + TAG_WIDTH;
  localparam logic [SEL_BITS:0] NUM_OUT_EXT = (SEL_BITS+1)'(NUM_OUTPUTS);

  logic [SEL_BITS-1:0]      w_sel;
  logic [TAG_WIDTH-1:0]     w_tag;
  logic                     w_sel_ok;
  logic                     w_xfer;
  logic [NUM_OUTPUTS-1:0]   w_full;
  logic [2**SEL_BITS-1:0]   w_full_pad;
  logic                     r_sel_error;

  assign w_sel    = bus.mem_rsp_tag[SEL_BITS-1:0];
  assign w_tag    = bus.mem_rsp_tag[TAG_WIDTH+SEL_BITS-1:SEL_BITS];
  assign w_sel_ok = ({1'b0, w_sel} < NUM_OUT_EXT);

  // Unpopulated select slots read as not-full so bad selects are always accepted.
  always_comb begin
    w_full_pad                = '0;
    w_full_pad[NUM_OUTPUTS-1:0] = w_full;
  end

  assign bus.mem_rsp_ready = !w_full_pad[w_sel];
  assign w_xfer            = bus.mem_rsp_valid && bus.mem_rsp_ready;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
    logic [1:0]       w_count;
    logic [ENT_W-1:0] w_head;
    logic             w_push;
    logic             w_pop;

    assign w_push = w_xfer && (w_sel == SEL_BITS'(i));
    assign w_pop  = bus.rsp_valid[i] && bus.rsp_ready[i];

    mem_rsp_skid_buf #(.WIDTH(ENT_W)) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({bus.mem_rsp_data, w_tag}),
      .count (w_count),
      .head  (w_head)
    );

    assign w_full[i]                               = (w_count == 2'd2);
    assign bus.rsp_valid[i]                        = (w_count != 2'd0);
    assign bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = w_head[ENT_W-1:TAG_WIDTH];
    assign bus.rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]    = w_head[TAG_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_error <= 1'b0;
    end else if (w_xfer && !w_sel_ok) begin
      r_sel_error <= 1'b1;
    end
  end

  assign sel_error = r_sel_error;

`ifdef MEM_RSP_ROUTER_PERF_EN
  logic [63:0] r_perf_rsp;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_rsp   <= 64'd0;
      r_perf_stall <= 64'd0;
    end else begin
      if (w_xfer && w_sel_ok) begin
        r_perf_rsp <= r_perf_rsp + 64'd1;
      end
      if (bus.mem_rsp_valid && !bus.mem_rsp_ready) begin
        r_perf_stall <= r_perf_stall + 64'd1;
      end
    end
  end

  assign perf_rsp_count    = r_perf_rsp;
  assign perf_stall_cycles = r_perf_stall;
`endif
endmodule

`default_nettype wire

// File: tb/tb_mem_rsp_router.sv
// tb_mem_rsp_router: directed vector table plus hand sequences for the response router.
// Revision 1.0
`default_nettype none

module tb_mem_rsp_router;
  import mem_rsp_router_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sel_error;
`ifdef MEM_RSP_ROUTER_PERF_EN
  logic [63:0] perf_rsp_count;
  logic [63:0] perf_stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_rsp_router_if #(.NUM_OUTPUTS(5), .DATA_WIDTH(512), .TAG_WIDTH(16)) bus ();

  mem_rsp_router #(.NUM_OUTPUTS(5), .DATA_WIDTH(512), .TAG_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
`ifdef MEM_RSP_ROUTER_PERF_EN
    .perf_rsp_count    (perf_rsp_count),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .sel_error         (sel_error)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic [15:0] utag;
    logic [31:0] dword;
    logic [4:0]  rdy;
    logic        exp_ready;
    logic [4:0]  exp_valid;
    logic        exp_err;
    int          chk;
    logic [15:0] chk_tag;
    logic [31:0] chk_dword;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [15:0] utag,
                       input logic [31:0] dword, input logic [4:0] rdy);
    bus.mem_rsp_valid = v;
    bus.mem_rsp_tag   = {utag, sel};
    bus.mem_rsp_data  = {16{dword}};
    bus.rsp_ready     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int idx, input logic [15:0] tag, input logic [31:0] dword);
    logic [15:0]  t;
    logic [511:0] d;
    t = bus.rsp_tag[idx*16 +: 16];
    d = bus.rsp_data[idx*512 +: 512];
    check({name, "_tag"}, 512'(t), 512'(tag));
    check({name, "_data"}, d, {16{dword}});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", 512'(bus.rsp_valid), 512'(5'b0));
    check("rst_async_err", 512'(sel_error), 512'(1'b0));
    check("rst_async_ready", 512'(bus.mem_rsp_ready), 512'(1'b1));
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    //            v   sel   utag      dword         rdy       rdy  valid     err chk tag       dword
    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b00000, 1'b0, -1, 16'h0,    32'h0};
    vecs[1]  = '{1'b1, 3'd3, 16'h1234, 32'hA5A5A5A5, 5'h1F,   1'b1, 5'b00000, 1'b0, -1, 16'h0,    32'h0};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b01000, 1'b0,  3, 16'h1234, 32'hA5A5A5A5};
    vecs[3]  = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b00000, 1'b0, -1, 16'h0,    32'h0};
    vecs[4]  = '{1'b1, 3'd0, 16'h0100, 32'h11111111, 5'b11110, 1'b1, 5'b00000, 1'b0, -1, 16'h0,    32'h0};
    vecs[5]  = '{1'b1, 3'd0, 16'h0101, 32'h22222222, 5'b11110, 1'b1, 5'b00001, 1'b0,  0, 16'h0100, 32'h11111111};
    vecs[6]  = '{1'b1, 3'd0, 16'h0102, 32'h33333333, 5'b11110, 1'b0, 5'b00001, 1'b0,  0, 16'h0100, 32'h11111111};
    vecs[7]  = '{1'b1, 3'd2, 16'h0200, 32'h44444444, 5'b11110, 1'b1, 5'b00001, 1'b0, -1, 16'h0,    32'h0};
    vecs[8]  = '{1'b0, 3'd2, 16'h0000, 32'h0,        5'b11110, 1'b1, 5'b00101, 1'b0,  2, 16'h0200, 32'h44444444};
    vecs[9]  = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b0, 5'b00001, 1'b0,  0, 16'h0100, 32'h11111111};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b00001, 1'b0,  0, 16'h0101, 32'h22222222};
    vecs[11] = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b00000, 1'b0, -1, 16'h0,    32'h0};
    vecs[12] = '{1'b1, 3'd6, 16'hBEEF, 32'hDEADBEEF, 5'h1F,   1'b1, 5'b00000, 1'b0, -1, 16'h0,    32'h0};
    vecs[13] = '{1'b0, 3'd0, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b00000, 1'b1, -1, 16'h0,    32'h0};
    vecs[14] = '{1'b1, 3'd5, 16'h0555, 32'h55555555, 5'h1F,   1'b1, 5'b00000, 1'b1, -1, 16'h0,    32'h0};
    vecs[15] = '{1'b0, 3'd7, 16'h0000, 32'h0,        5'h1F,   1'b1, 5'b00000, 1'b1, -1, 16'h0,    32'h0};

    reset = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 5'h1F);
    @(negedge clk);
    check("reset_valid", 512'(bus.rsp_valid), 512'(5'b0));
    check("reset_err", 512'(sel_error), 512'(1'b0));
    check("reset_ready", 512'(bus.mem_rsp_ready), 512'(1'b1));
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].sel, vecs[i].utag, vecs[i].dword, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d_ready", i), 512'(bus.mem_rsp_ready), 512'(vecs[i].exp_ready));
      check($sformatf("v%0d_valid", i), 512'(bus.rsp_valid), 512'(vecs[i].exp_valid));
      check($sformatf("v%0d_err", i), 512'(sel_error), 512'(vecs[i].exp_err));
      if (vecs[i].chk >= 0) begin
        check_out($sformatf("v%0d_out%0d", i, vecs[i].chk), vecs[i].chk, vecs[i].chk_tag, vecs[i].chk_dword);
      end
      next_cycle();
    end

    // Back-to-back stream to the dcache slot: one in, one out every cycle.
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1'b1, 3'(DCACHE_RSP_IDX), 16'h1000 + 16'(k), 32'hB0000000 + k, 5'h1F);
      else       drive(1'b0, 3'd0, 16'h0, 32'h0, 5'h1F);
      @(negedge clk);
      if (k < 8) check($sformatf("b2b%0d_ready", k), 512'(bus.mem_rsp_ready), 512'(1'b1));
      if (k >= 1) begin
        check($sformatf("b2b%0d_valid", k), 512'(bus.rsp_valid), 512'(5'b00010));
        check_out($sformatf("b2b%0d", k), 1, 16'h1000 + 16'(k - 1), 32'hB0000000 + (k - 1));
      end
      next_cycle();
    end
    @(negedge clk);
    check("b2b_drained", 512'(bus.rsp_valid), 512'(5'b0));
    next_cycle();

    // Fill outputs 0 and 4 to two entries each, then reset in the middle of a cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k < 2) ? 3'd0 : 3'd4, 16'h0A00 + 16'(k), 32'hC0000000 + k, 5'b01110);
      next_cycle();
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 5'b01110);
    @(negedge clk);
    check("fill_valid", 512'(bus.rsp_valid), 512'(5'b10001));
    check("fill_ready0", 512'(bus.mem_rsp_ready), 512'(1'b0));
    check("fill_err_held", 512'(sel_error), 512'(1'b1));
    pulse_reset();

    drive(1'b1, 3'd4, 16'h4444, 32'h44440000, 5'h1F);
    @(negedge clk);
    check("post_rst_ready", 512'(bus.mem_rsp_ready), 512'(1'b1));
    next_cycle();
    drive(1'b0, 3'd0, 16'h0, 32'h0, 5'h1F);
    @(negedge clk);
    check("post_rst_valid", 512'(bus.rsp_valid), 512'(5'b10000));
    check_out("post_rst_out4", 4, 16'h4444, 32'h44440000);
    next_cycle();

`ifdef MEM_RSP_ROUTER_PERF_EN
    pulse_reset();
    check("perf_reset_rsp", 512'(perf_rsp_count), 512'(64'd0));
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'd1, 16'h2000 + 16'(k), 32'h0, 5'h1F);
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'd0, 16'h3000 + 16'(k), 32'h0, 5'b11110);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 16'h3100, 32'h0, 5'b11110);
      @(negedge clk);
      check($sformatf("perf_stall%0d_ready", k), 512'(bus.mem_rsp_ready), 512'(1'b0));
      next_cycle();
    end
    drive(1'b0, 3'd1, 16'h0, 32'h0, 5'b11110);
    @(negedge clk);
    check("perf_rsp_count", 512'(perf_rsp_count), 512'(64'd10));
    check("perf_stall_cycles", 512'(perf_stall_cycles), 512'(64'd3));
    next_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
